// File: rtl/pipelined_addsub.sv
// Carry-chained add/subtract and compare pipeline: STAGES register stages, each summing one CHUNK.
// Optional result clamping on overflow is compiled in with the ADDSUB_SATURATE_EN macro.
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  input  logic             in_unsigned,
  input  logic             in_sat,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_ne,
  output logic             out_lt,
  output logic             out_ovf,
  output logic             out_cout,
  output logic [TAG_W-1:0] out_tag
);

  localparam int CHUNK = WIDTH / STAGES;

  // Handshake: a beat moves on an edge where valid && ready. The whole pipe
  // advances together; it stalls only when the output holds an unconsumed beat.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

`ifndef ADDSUB_SATURATE_EN
  logic unused_sat;
  assign unused_sat = in_sat;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : stg
    // Operand bits not yet summed when entering this stage
    localparam int REM = WIDTH - k * CHUNK;

    logic                   src_v;
    logic [REM-1:0]         src_a;
    logic [REM-1:0]         src_b;
    logic                   src_c;
    logic                   src_nz;
    logic                   src_op;
    logic                   src_uns;
    logic [TAG_W-1:0]       src_tag;
`ifdef ADDSUB_SATURATE_EN
    logic                   src_sat;
`endif
    logic [CHUNK:0]         sum;
    logic [(k+1)*CHUNK-1:0] r_d;
    logic                   nz_d;
    logic                   v_q;

    assign sum  = {1'b0, src_a[CHUNK-1:0]} + {1'b0, src_b[CHUNK-1:0]}
                + {{CHUNK{1'b0}}, src_c};
    assign nz_d = src_nz | (|sum[CHUNK-1:0]);

    if (k == 0) begin : g_src
      // Subtraction is A + ~B + 1: the +1 rides in as the stage-0 carry.
      assign src_v   = in_valid;
      assign src_a   = in_a;
      assign src_b   = in_op ? ~in_b : in_b;
      assign src_c   = in_op;
      assign src_nz  = 1'b0;
      assign src_op  = in_op;
      assign src_uns = in_unsigned;
      assign src_tag = in_tag;
`ifdef ADDSUB_SATURATE_EN
      assign src_sat = in_sat;
`endif
      assign r_d     = sum[CHUNK-1:0];
    end else begin : g_src
      assign src_v   = stg[k-1].v_q;
      assign src_a   = stg[k-1].g_reg.a_q;
      assign src_b   = stg[k-1].g_reg.b_q;
      assign src_c   = stg[k-1].g_reg.c_q;
      assign src_nz  = stg[k-1].g_reg.nz_q;
      assign src_op  = stg[k-1].g_reg.op_q;
      assign src_uns = stg[k-1].g_reg.uns_q;
      assign src_tag = stg[k-1].g_reg.tag_q;
`ifdef ADDSUB_SATURATE_EN
      assign src_sat = stg[k-1].g_reg.sat_q;
`endif
      assign r_d     = {sum[CHUNK-1:0], stg[k-1].g_reg.r_q};
    end

    // Valid bits shift with the pipe so bubbles hold in place during a stall.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        v_q <= 1'b0;
      end else if (advance) begin
        v_q <= src_v;
      end
    end

    if (k < STAGES - 1) begin : g_reg
      logic [REM-CHUNK-1:0]   a_q;
      logic [REM-CHUNK-1:0]   b_q;
      logic [(k+1)*CHUNK-1:0] r_q;
      logic                   c_q;
      logic                   nz_q;
      logic                   op_q;
      logic                   uns_q;
      logic [TAG_W-1:0]       tag_q;
`ifdef ADDSUB_SATURATE_EN
      logic                   sat_q;
`endif

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          a_q   <= '0;
          b_q   <= '0;
          r_q   <= '0;
          c_q   <= 1'b0;
          nz_q  <= 1'b0;
          op_q  <= 1'b0;
          uns_q <= 1'b0;
          tag_q <= '0;
`ifdef ADDSUB_SATURATE_EN
          sat_q <= 1'b0;
`endif
        end else if (advance && src_v) begin
          a_q   <= src_a[REM-1:CHUNK];
          b_q   <= src_b[REM-1:CHUNK];
          r_q   <= r_d;
          c_q   <= sum[CHUNK];
          nz_q  <= nz_d;
          op_q  <= src_op;
          uns_q <= src_uns;
          tag_q <= src_tag;
`ifdef ADDSUB_SATURATE_EN
          sat_q <= src_sat;
`endif
        end
      end
    end else begin : g_last
      logic [WIDTH-1:0] res_q;
      logic [WIDTH-1:0] res_d;
      logic             ne_q;
      logic             lt_q;
      logic             ovf_q;
      logic             cout_q;
      logic [TAG_W-1:0] tag_q;
      logic             a_msb;
      logic             b_msb;
      logic             r_msb;
      logic             ovf_s;
      logic             ovf_d;
      logic             lt_d;

      // The top chunk holds the operand sign bits, so flags resolve here.
      always_comb begin
        a_msb = src_a[CHUNK-1];
        b_msb = src_b[CHUNK-1];
        r_msb = r_d[WIDTH-1];
        ovf_s = (a_msb == b_msb) && (r_msb != a_msb);
        ovf_d = ovf_s;
        lt_d  = 1'b0;
        res_d = r_d;
        if (src_uns) begin
          ovf_d = src_op ? !sum[CHUNK] : sum[CHUNK];
          lt_d  = src_op && !sum[CHUNK];
        end else begin
          lt_d  = src_op && (r_msb ^ ovf_s);
        end
`ifdef ADDSUB_SATURATE_EN
        if (src_sat && ovf_d) begin
          if (src_uns) begin
            res_d = src_op ? '0 : '1;
          end else begin
            res_d = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
          end
        end
`endif
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          res_q  <= '0;
          ne_q   <= 1'b0;
          lt_q   <= 1'b0;
          ovf_q  <= 1'b0;
          cout_q <= 1'b0;
          tag_q  <= '0;
        end else if (advance && src_v) begin
          res_q  <= res_d;
          ne_q   <= nz_d;
          lt_q   <= lt_d;
          ovf_q  <= ovf_d;
          cout_q <= sum[CHUNK];
          tag_q  <= src_tag;
        end
      end
    end
  end

  assign out_valid  = stg[STAGES-1].v_q;
  assign out_result = stg[STAGES-1].g_last.res_q;
  assign out_ne     = stg[STAGES-1].g_last.ne_q;
  assign out_lt     = stg[STAGES-1].g_last.lt_q;
  assign out_ovf    = stg[STAGES-1].g_last.ovf_q;
  assign out_cout   = stg[STAGES-1].g_last.cout_q;
  assign out_tag    = stg[STAGES-1].g_last.tag_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub (WIDTH=32, STAGES=4, TAG_W=5): directed beats, a back-pressured stream
// and a mid-stream reset, checked through an expected-result queue.
module tb_pipelined_addsub;

  localparam int W     = 32;
  localparam int ST    = 4;
  localparam int TAG_W = 5;
  localparam int EXP_W = TAG_W + W + 4;

  logic             clock;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             in_op;
  logic             in_unsigned;
  logic             in_sat;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_result;
  logic             out_ne;
  logic             out_lt;
  logic             out_ovf;
  logic             out_cout;
  logic [TAG_W-1:0] out_tag;

  int checks = 0;
  int errors = 0;

  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] held;
  logic             held_v;

  pipelined_addsub #(.WIDTH(W), .STAGES(ST), .TAG_W(TAG_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_op       (in_op),
    .in_unsigned (in_unsigned),
    .in_sat      (in_sat),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_ne      (out_ne),
    .out_lt      (out_lt),
    .out_ovf     (out_ovf),
    .out_cout    (out_cout),
    .out_tag     (out_tag)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic logic [EXP_W-1:0] pack(input logic [TAG_W-1:0] tag, input logic [W-1:0] res,
                                            input logic ne, input logic lt, input logic ovf,
                                            input logic cout);
    return {tag, res, ne, lt, ovf, cout};
  endfunction

  // Reference built from true-value arithmetic, not from the carry chain
  function automatic logic [EXP_W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic op, input logic uns,
                                             input logic [TAG_W-1:0] tag);
    logic [W-1:0] r;
    logic [W:0]   s;
    logic [W:0]   u;
    logic         cout;
    logic         ovf;
    logic         lt;
    if (op) begin
      r    = a - b;
      s    = {a[W-1], a} - {b[W-1], b};
      cout = (a >= b);
    end else begin
      r    = a + b;
      s    = {a[W-1], a} + {b[W-1], b};
      u    = {1'b0, a} + {1'b0, b};
      cout = u[W];
    end
    if (uns) begin
      ovf = op ? (a < b) : cout;
      lt  = op && (a < b);
    end else begin
      ovf = s[W] ^ s[W-1];
      lt  = op && ($signed(a) < $signed(b));
    end
    return {tag, r, (r != '0), lt, ovf, cout};
  endfunction

  // driver: one beat, expected value queued when the beat is accepted
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                      input logic uns, input logic sat, input logic [TAG_W-1:0] tag,
                      input logic [EXP_W-1:0] exp);
    int n;
    n = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
    in_unsigned = uns; in_sat = sat; in_tag = tag;
    @(negedge clock);
    while (!in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (in_ready) exp_q.push_back(exp);
    else chk("send_timeout", 64'(n), 64'd0);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_latency(input string name, input int exp_lat);
    int c;
    c = 0;
    while (c < 50) begin
      @(negedge clock);
      if (out_valid) break;
      c++;
    end
    chk(name, 64'(c), 64'(exp_lat));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clock);
      n++;
    end
    #1;
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_idle(input string name);
    chk({name, "_valid"}, 64'(out_valid), 64'd0);
    chk({name, "_ready"}, 64'(in_ready), 64'd1);
    chk({name, "_outs"}, 64'(pack(out_tag, out_result, out_ne, out_lt, out_ovf, out_cout)), 64'd0);
  endtask

  // scoreboard: pop on consume, hold-stability while stalled
  always @(negedge clock) begin
    logic [EXP_W-1:0] obs;
    if (reset) begin
      held_v = 1'b0;
    end else if (out_valid) begin
      obs = pack(out_tag, out_result, out_ne, out_lt, out_ovf, out_cout);
      if (held_v) chk("stall_stable", 64'(obs), 64'(held));
      if (out_ready) begin
        held_v = 1'b0;
        if (exp_q.size() == 0) chk("unexpected_beat", 64'(obs), 64'd0);
        else chk("result", 64'(obs), 64'(exp_q.pop_front()));
      end else begin
        held_v = 1'b1;
        held   = obs;
      end
    end
  end

  initial begin
    logic [EXP_W-1:0] sat_add_exp;
    logic [EXP_W-1:0] sat_sub_exp;
    logic [W-1:0]     ra;
    logic [W-1:0]     rb;
    logic             rop;
    logic             runs;
    logic             acc;
    int               i;
    int               cyc;

    held_v = 1'b0;
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0;
    in_unsigned = 1'b0; in_sat = 1'b0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_idle("reset_in");
    reset = 1'b0;
    #1;
    check_idle("reset_out");

    // single signed sub, latency STAGES-1
    send(32'd5, 32'd9, 1'b1, 1'b0, 1'b0, 5'd3, pack(5'd3, 32'hFFFF_FFFC, 1, 1, 0, 0));
    check_latency("latency_first", ST - 1);
    drain("drain_sub");

    // carries, compares, boundaries
    send(32'h00FF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, 5'd4, pack(5'd4, 32'h0100_0000, 1, 0, 0, 0));
    send(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 1'b0, 5'd5, pack(5'd5, 32'h0000_0000, 0, 0, 1, 1));
    send(32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b0, 5'd6, pack(5'd6, 32'hFFFF_FFFE, 1, 1, 0, 1));
    send(32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 1'b0, 5'd7, pack(5'd7, 32'hFFFF_FFFE, 1, 0, 0, 1));
    send(32'h8000_0000, 32'd1, 1'b1, 1'b0, 1'b0, 5'd8, pack(5'd8, 32'h7FFF_FFFF, 1, 1, 1, 1));
    send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 5'd9, pack(5'd9, 32'h8000_0000, 1, 0, 1, 0));
    send(32'h0000_1234, 32'h0000_1234, 1'b1, 1'b0, 1'b0, 5'd10, pack(5'd10, 32'h0, 0, 0, 0, 1));
    send(32'd1, 32'd2, 1'b1, 1'b1, 1'b0, 5'd11, pack(5'd11, 32'hFFFF_FFFF, 1, 1, 1, 0));
    drain("drain_directed");

    // saturation: clamped with the macro, wrapped without it
`ifdef ADDSUB_SATURATE_EN
    sat_add_exp = pack(5'd12, 32'h7FFF_FFFF, 1, 0, 1, 0);
    sat_sub_exp = pack(5'd13, 32'h0000_0000, 1, 1, 1, 0);
`else
    sat_add_exp = pack(5'd12, 32'h8000_0000, 1, 0, 1, 0);
    sat_sub_exp = pack(5'd13, 32'hFFFF_FFFE, 1, 1, 1, 0);
`endif
    send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, 5'd12, sat_add_exp);
    send(32'd3, 32'd5, 1'b1, 1'b1, 1'b1, 5'd13, sat_sub_exp);
    send(32'd1, 32'd2, 1'b0, 1'b0, 1'b1, 5'd14, pack(5'd14, 32'd3, 1, 0, 0, 0));
    drain("drain_sat");

    // back-pressure: 8 random beats, out_ready low for 5 cycles mid-stream
    i = 0;
    cyc = 0;
    while (i < 8 && cyc < 100) begin
      out_ready = !(cyc >= 4 && cyc < 9);
      if (in_valid == 1'b0 || acc) begin
        ra   = $urandom_range(32'hFFFF_FFFF, 0);
        rb   = (i == 3) ? ra : $urandom_range(32'hFFFF_FFFF, 0);
        rop  = 1'($urandom_range(1, 0));
        runs = 1'($urandom_range(1, 0));
      end
      in_valid = 1'b1; in_a = ra; in_b = rb; in_op = rop;
      in_unsigned = runs; in_sat = 1'b0; in_tag = 5'(i);
      @(negedge clock);
      if (cyc == 6) begin
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
      end
      acc = in_ready;
      if (acc) exp_q.push_back(model(ra, rb, rop, runs, 5'(i)));
      @(posedge clock); #1;
      if (acc) i++;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_accepted", 64'(i), 64'd8);
    drain("drain_stream");

    // reset with 3 beats in flight
    send(32'd1, 32'd2, 1'b0, 1'b0, 1'b0, 5'd20, pack(5'd20, 32'd3, 1, 0, 0, 0));
    send(32'd7, 32'd2, 1'b1, 1'b0, 1'b0, 5'd21, pack(5'd21, 32'd5, 1, 0, 0, 1));
    send(32'd9, 32'd9, 1'b0, 1'b1, 1'b0, 5'd22, pack(5'd22, 32'd18, 1, 0, 0, 0));
    reset = 1'b1;
    #1;
    exp_q.delete();
    check_idle("midreset");
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    chk("flushed_valid", 64'(out_valid), 64'd0);
    send(32'd100, 32'd1, 1'b1, 1'b1, 1'b0, 5'd23, pack(5'd23, 32'd99, 1, 0, 0, 1));
    check_latency("latency_after_reset", ST - 1);
    drain("drain_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
